// File: rtl/scr_base_l3_bk_tp_d3_wsel_if.sv
// D2 -> D3 -> D4 signal bundle for the L3 bank tag-pipe D3 stage.
// The slave side is the D3 stage; the master side is the surrounding pipe.
interface scr_base_l3_bk_tp_d3_wsel_if #(
  parameter int WAYS  = 8,
  parameter int TAG_W = 24,
  parameter int SET_W = 10,
  parameter int ID_W  = 6
);
  logic                    d2_vld_i;
  logic                    d2_rdy_o;
  logic [ID_W-1:0]         d2_id_i;
  logic [SET_W-1:0]        d2_set_i;
  logic [TAG_W-1:0]        d2_tag_i;
  logic                    d2_alloc_i;
  logic [WAYS*TAG_W-1:0]   d2_way_tag_i;
  logic [WAYS-1:0]         d2_way_vld_i;
  logic [WAYS-1:0]         d2_way_lock_i;
  logic                    d3_vld_o;
  logic                    d3_rdy_i;
  logic [ID_W-1:0]         d3_id_o;
  logic [SET_W-1:0]        d3_set_o;
  logic                    d3_hit_o;
  logic [WAYS-1:0]         d3_way_o;
  logic                    d3_evict_o;
  logic                    d3_noway_o;
  logic                    d3_replay_o;
  logic                    d3_mhit_err_o;
  logic [7:0]              mhit_cnt_o;

  modport slave (
    input  d2_vld_i, d2_id_i, d2_set_i, d2_tag_i, d2_alloc_i,
           d2_way_tag_i, d2_way_vld_i, d2_way_lock_i, d3_rdy_i,
    output d2_rdy_o, d3_vld_o, d3_id_o, d3_set_o, d3_hit_o, d3_way_o,
           d3_evict_o, d3_noway_o, d3_replay_o, d3_mhit_err_o, mhit_cnt_o
  );

  modport master (
    output d2_vld_i, d2_id_i, d2_set_i, d2_tag_i, d2_alloc_i,
           d2_way_tag_i, d2_way_vld_i, d2_way_lock_i, d3_rdy_i,
    input  d2_rdy_o, d3_vld_o, d3_id_o, d3_set_o, d3_hit_o, d3_way_o,
           d3_evict_o, d3_noway_o, d3_replay_o, d3_mhit_err_o, mhit_cnt_o
  );
endinterface

// File: rtl/scr_base_l3_bk_tp_d3_wsel.sv
// L3 bank tag pipe D3: tag compare, hit/victim way select, replay and
// multi-hit detection, registered into a one-entry slot towards D4.
module scr_base_l3_bk_tp_d3_wsel #(
  parameter int WAYS  = 8,
  parameter int TAG_W = 24,
  parameter int SET_W = 10,
  parameter int ID_W  = 6
) (
  input logic clk,
  input logic rst_n,
  scr_base_l3_bk_tp_d3_wsel_if.slave bus
);
  localparam int PTR_W = $clog2(WAYS);

  logic [WAYS-1:0]  match, elig, inv_elig;
  logic [PTR_W-1:0] hit_idx, inv_idx, rr_idx, cand;
  logic             rr_found, hit_c, mhit_c, replay_c, accept;
  logic             hit_n, evict_n, noway_n, mhit_n, rr_upd;
  logic [WAYS-1:0]  way_n;
  logic [PTR_W-1:0] rr_n;

  logic             vld_q, hit_q, evict_q, noway_q, replay_q, mhit_q, alloc_q;
  logic [ID_W-1:0]  id_q;
  logic [SET_W-1:0] set_q;
  logic [WAYS-1:0]  way_q;
  logic [PTR_W-1:0] rr_ptr;
  logic [7:0]       cnt_q;

  assign bus.d2_rdy_o = !vld_q || bus.d3_rdy_i;
  assign accept       = bus.d2_vld_i && bus.d2_rdy_o;
  assign elig         = ~bus.d2_way_lock_i;
  assign inv_elig     = elig & ~bus.d2_way_vld_i;

  always_comb begin
    match   = '0;
    hit_idx = '0;
    inv_idx = '0;
    for (int k = 0; k < WAYS; k++)
      match[k] = bus.d2_way_vld_i[k] && (bus.d2_way_tag_i[k*TAG_W +: TAG_W] == bus.d2_tag_i);
    for (int k = WAYS - 1; k >= 0; k--) begin
      if (match[k])    hit_idx = PTR_W'(k);
      if (inv_elig[k]) inv_idx = PTR_W'(k);
    end
  end

  // Round-robin search starts at rr_ptr; pointer arithmetic wraps since WAYS is a power of 2.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = '0;
    for (int i = 0; i < WAYS; i++) begin
      cand = rr_ptr + PTR_W'(i);
      if (!rr_found && elig[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
  end

  assign hit_c    = |match;
  assign mhit_c   = (match & (match - WAYS'(1))) != '0;
  assign replay_c = vld_q && !hit_q && alloc_q && !noway_q && !replay_q &&
                    (bus.d2_set_i == set_q);

  always_comb begin
    hit_n   = 1'b0;
    way_n   = '0;
    evict_n = 1'b0;
    noway_n = 1'b0;
    mhit_n  = 1'b0;
    rr_upd  = 1'b0;
    rr_n    = rr_ptr;
    if (replay_c) begin
      hit_n = 1'b0;
    end else if (hit_c) begin
      hit_n  = 1'b1;
      way_n  = WAYS'(1) << hit_idx;
      mhit_n = mhit_c;
    end else if (bus.d2_alloc_i) begin
      if (|inv_elig) begin
        way_n = WAYS'(1) << inv_idx;
      end else if (rr_found) begin
        way_n   = WAYS'(1) << rr_idx;
        evict_n = 1'b1;
        rr_upd  = 1'b1;
        rr_n    = rr_idx + PTR_W'(1);
      end else begin
        noway_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q    <= 1'b0;
      id_q     <= '0;
      set_q    <= '0;
      hit_q    <= 1'b0;
      way_q    <= '0;
      evict_q  <= 1'b0;
      noway_q  <= 1'b0;
      replay_q <= 1'b0;
      mhit_q   <= 1'b0;
      alloc_q  <= 1'b0;
      rr_ptr   <= '0;
      cnt_q    <= '0;
    end else if (accept) begin
      vld_q    <= 1'b1;
      id_q     <= bus.d2_id_i;
      set_q    <= bus.d2_set_i;
      hit_q    <= hit_n;
      way_q    <= way_n;
      evict_q  <= evict_n;
      noway_q  <= noway_n;
      replay_q <= replay_c;
      mhit_q   <= mhit_n;
      alloc_q  <= bus.d2_alloc_i;
      if (rr_upd) rr_ptr <= rr_n;
      if (mhit_n && cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
    end else if (bus.d3_rdy_i) begin
      vld_q <= 1'b0;
    end
  end

  assign bus.d3_vld_o      = vld_q;
  assign bus.d3_id_o       = id_q;
  assign bus.d3_set_o      = set_q;
  assign bus.d3_hit_o      = hit_q;
  assign bus.d3_way_o      = way_q;
  assign bus.d3_evict_o    = evict_q;
  assign bus.d3_noway_o    = noway_q;
  assign bus.d3_replay_o   = replay_q;
  assign bus.d3_mhit_err_o = mhit_q;
  assign bus.mhit_cnt_o    = cnt_q;
endmodule

// File: tb/tb_scr_base_l3_bk_tp_d3_wsel.sv
// Bench for the D3 way-select stage: directed scenarios plus randomized traffic
// checked against a behavioural request-level model.
module tb_scr_base_l3_bk_tp_d3_wsel;
  localparam int WAYS  = 8;
  localparam int TAG_W = 24;
  localparam int SET_W = 10;
  localparam int ID_W  = 6;
  localparam int OW    = 1 + ID_W + SET_W + 1 + WAYS + 4 + 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  scr_base_l3_bk_tp_d3_wsel_if #(.WAYS(WAYS), .TAG_W(TAG_W), .SET_W(SET_W), .ID_W(ID_W)) bus();

  scr_base_l3_bk_tp_d3_wsel #(.WAYS(WAYS), .TAG_W(TAG_W), .SET_W(SET_W), .ID_W(ID_W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [TAG_W-1:0] tg [WAYS];

  // Model of the held D3 entry, rr pointer and error counter.
  bit               m_vld, m_hit, m_evict, m_noway, m_replay, m_mhit, m_alloc;
  logic [ID_W-1:0]  m_id;
  logic [SET_W-1:0] m_set;
  logic [WAYS-1:0]  m_way;
  int               m_rr, m_cnt;

  function automatic logic [OW-1:0] exp_vec();
    return {m_vld, m_id, m_set, m_hit, m_way, m_evict, m_noway, m_replay, m_mhit, 8'(m_cnt)};
  endfunction

  function automatic logic [OW-1:0] act_vec();
    return {bus.d3_vld_o, bus.d3_id_o, bus.d3_set_o, bus.d3_hit_o, bus.d3_way_o, bus.d3_evict_o,
            bus.d3_noway_o, bus.d3_replay_o, bus.d3_mhit_err_o, bus.mhit_cnt_o};
  endfunction

  task automatic model_reset();
    m_vld = 0; m_hit = 0; m_evict = 0; m_noway = 0; m_replay = 0; m_mhit = 0; m_alloc = 0;
    m_id = '0; m_set = '0; m_way = '0; m_rr = 0; m_cnt = 0;
  endtask

  // Applies one cycle of D2/D4 stimulus, advances the model, returns at posedge+1.
  task automatic drive(input logic vld, input logic [ID_W-1:0] id, input logic [SET_W-1:0] set,
                       input logic [TAG_W-1:0] tag, input logic alloc, input logic [WAYS-1:0] wvld,
                       input logic [WAYS-1:0] lock, input logic rdy);
    bit acc, rep, nh, ne, nn, nm;
    logic [WAYS-1:0] nw;
    int n, first, inv, vic, nrr;
    bus.d2_vld_i      = vld;
    bus.d2_id_i       = id;
    bus.d2_set_i      = set;
    bus.d2_tag_i      = tag;
    bus.d2_alloc_i    = alloc;
    bus.d2_way_vld_i  = wvld;
    bus.d2_way_lock_i = lock;
    bus.d3_rdy_i      = rdy;
    for (int k = 0; k < WAYS; k++) bus.d2_way_tag_i[k*TAG_W +: TAG_W] = tg[k];
    acc = vld && (!m_vld || rdy);
    n = 0; first = -1; inv = -1; vic = -1;
    for (int k = 0; k < WAYS; k++)
      if (wvld[k] && tg[k] == tag) begin
        n++;
        if (first < 0) first = k;
      end
    rep = m_vld && !m_hit && m_alloc && !m_noway && !m_replay && (set == m_set);
    nh = 0; ne = 0; nn = 0; nm = 0; nw = '0; nrr = m_rr;
    if (rep) begin
      nh = 0;
    end else if (n > 0) begin
      nh = 1; nw[first] = 1'b1; nm = (n > 1);
    end else if (alloc) begin
      for (int k = WAYS - 1; k >= 0; k--) if (!lock[k] && !wvld[k]) inv = k;
      for (int j = 0; j < WAYS; j++) if (vic < 0 && !lock[(m_rr + j) % WAYS]) vic = (m_rr + j) % WAYS;
      if (inv >= 0) nw[inv] = 1'b1;
      else if (vic >= 0) begin nw[vic] = 1'b1; ne = 1; nrr = (vic + 1) % WAYS; end
      else nn = 1;
    end
    @(posedge clk);
    if (acc) begin
      m_vld = 1; m_id = id; m_set = set; m_hit = nh; m_way = nw; m_evict = ne; m_noway = nn;
      m_replay = rep; m_mhit = nm; m_alloc = alloc; m_rr = nrr;
      if (nm && m_cnt < 255) m_cnt++;
    end else if (rdy) begin
      m_vld = 0;
    end
    #1;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, '0, 1'b0, '0, '0, 1'b1);
  endtask

  task automatic distinct_tags();
    for (int k = 0; k < WAYS; k++) tg[k] = TAG_W'(24'h100000 + k);
  endtask

  task automatic test_reset();
    bus.d2_vld_i = 0; bus.d2_id_i = '0; bus.d2_set_i = '0; bus.d2_tag_i = '0; bus.d2_alloc_i = 0;
    bus.d2_way_tag_i = '0; bus.d2_way_vld_i = '0; bus.d2_way_lock_i = '0; bus.d3_rdy_i = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (act_vec() !== '0) begin errors++; $display("FAIL reset_outputs: got %h want 0", act_vec()); end
    rst_n = 1'b1;
  endtask

  task automatic test_single_hit();
    distinct_tags();
    tg[5] = 24'h123;
    drive(1'b1, 6'd3, 10'h5, 24'h123, 1'b0, 8'hFF, 8'h00, 1'b1);
    checks++;
    if (!(bus.d3_vld_o === 1'b1 && bus.d3_hit_o === 1'b1 && bus.d3_way_o === 8'h20 && bus.d3_replay_o === 1'b0)) begin
      errors++; $display("FAIL single_hit: got vld=%b hit=%b way=%h replay=%b want 1 1 20 0",
                         bus.d3_vld_o, bus.d3_hit_o, bus.d3_way_o, bus.d3_replay_o);
    end
    checks++;
    if (act_vec() !== exp_vec()) begin errors++; $display("FAIL single_hit_model: got %h want %h", act_vec(), exp_vec()); end
    idle();
    checks++;
    if (bus.d3_vld_o !== 1'b0) begin errors++; $display("FAIL drain_vld: got %b want 0", bus.d3_vld_o); end
  endtask

  task automatic test_invalid_first();
    distinct_tags();
    drive(1'b1, 6'd1, 10'h10, 24'hABC, 1'b1, 8'hF3, 8'h00, 1'b1);
    checks++;
    if (!(bus.d3_way_o === 8'h04 && bus.d3_evict_o === 1'b0 && bus.d3_noway_o === 1'b0)) begin
      errors++; $display("FAIL invalid_first: got way=%h evict=%b noway=%b want 04 0 0",
                         bus.d3_way_o, bus.d3_evict_o, bus.d3_noway_o);
    end
  endtask

  task automatic test_round_robin();
    logic [WAYS-1:0] exp_w [4];
    exp_w = '{8'h02, 8'h04, 8'h08, 8'h10};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, ID_W'(i), SET_W'(10'h11 + i), 24'hABC, 1'b1, 8'hFF, 8'h01, 1'b1);
      checks++;
      if (!(bus.d3_way_o === exp_w[i] && bus.d3_evict_o === 1'b1 && bus.d3_hit_o === 1'b0)) begin
        errors++; $display("FAIL round_robin_%0d: got way=%h evict=%b want %h 1", i, bus.d3_way_o, bus.d3_evict_o, exp_w[i]);
      end
    end
    drive(1'b1, 6'd9, 10'h15, 24'hABC, 1'b1, 8'hFF, 8'hFF, 1'b1);
    checks++;
    if (!(bus.d3_noway_o === 1'b1 && bus.d3_way_o === 8'h00 && bus.d3_evict_o === 1'b0)) begin
      errors++; $display("FAIL all_locked: got noway=%b way=%h evict=%b want 1 00 0", bus.d3_noway_o, bus.d3_way_o, bus.d3_evict_o);
    end
    idle();
  endtask

  task automatic test_replay();
    distinct_tags();
    drive(1'b1, 6'd10, 10'h2A, 24'hABC, 1'b1, 8'hFF, 8'h00, 1'b1);
    checks++;
    if (bus.d3_way_o !== 8'h20) begin errors++; $display("FAIL replay_setup_way: got %h want 20", bus.d3_way_o); end
    drive(1'b1, 6'd11, 10'h2A, tg[1], 1'b1, 8'hFF, 8'h00, 1'b1);
    checks++;
    if (!(bus.d3_replay_o === 1'b1 && bus.d3_hit_o === 1'b0 && bus.d3_way_o === 8'h00 && bus.d3_mhit_err_o === 1'b0)) begin
      errors++; $display("FAIL replay_same_set: got replay=%b hit=%b way=%h want 1 0 00",
                         bus.d3_replay_o, bus.d3_hit_o, bus.d3_way_o);
    end
    drive(1'b1, 6'd12, 10'h2A, 24'hABC, 1'b1, 8'hFF, 8'h00, 1'b1);
    checks++;
    if (!(bus.d3_replay_o === 1'b0 && bus.d3_way_o === 8'h40)) begin
      errors++; $display("FAIL replay_rr_kept: got replay=%b way=%h want 0 40", bus.d3_replay_o, bus.d3_way_o);
    end
    drive(1'b1, 6'd13, 10'h2B, 24'hABC, 1'b1, 8'hFF, 8'h00, 1'b1);
    checks++;
    if (!(bus.d3_replay_o === 1'b0 && bus.d3_way_o === 8'h80)) begin
      errors++; $display("FAIL no_replay_other_set: got replay=%b way=%h want 0 80", bus.d3_replay_o, bus.d3_way_o);
    end
    idle();
  endtask

  task automatic test_stall_mhit();
    logic [OW-1:0] snap;
    distinct_tags();
    tg[2] = 24'h777;
    tg[6] = 24'h777;
    drive(1'b1, 6'd20, 10'h30, 24'h777, 1'b0, 8'hFF, 8'h00, 1'b1);
    checks++;
    if (!(bus.d3_way_o === 8'h04 && bus.d3_mhit_err_o === 1'b1 && bus.mhit_cnt_o === 8'd1 && bus.d3_hit_o === 1'b1)) begin
      errors++; $display("FAIL multi_hit: got way=%h mhit=%b cnt=%0d want 04 1 1", bus.d3_way_o, bus.d3_mhit_err_o, bus.mhit_cnt_o);
    end
    snap = act_vec();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 6'd21, 10'h31, 24'h777, 1'b1, 8'hFF, 8'h00, 1'b0);
      checks++;
      if (!(bus.d2_rdy_o === 1'b0 && act_vec() === snap)) begin
        errors++; $display("FAIL stall_%0d: got rdy=%b out=%h want 0 %h", i, bus.d2_rdy_o, act_vec(), snap);
      end
    end
    drive(1'b1, 6'd22, 10'h32, 24'h999, 1'b0, 8'hFF, 8'h00, 1'b1);
    checks++;
    if (act_vec() !== exp_vec()) begin errors++; $display("FAIL stall_release: got %h want %h", act_vec(), exp_vec()); end
  endtask

  task automatic test_mhit_saturate();
    distinct_tags();
    tg[2] = 24'h777;
    tg[6] = 24'h777;
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, ID_W'(i), 10'h40, 24'h777, 1'b0, 8'hFF, 8'h00, 1'b1);
      checks++;
      if (act_vec() !== exp_vec()) begin errors++; $display("FAIL mhit_seq_%0d: got %h want %h", i, act_vec(), exp_vec()); end
    end
    checks++;
    if (bus.mhit_cnt_o !== 8'd255) begin errors++; $display("FAIL mhit_saturate: got %0d want 255", bus.mhit_cnt_o); end
    idle();
  endtask

  task automatic test_reset_mid_stall();
    distinct_tags();
    drive(1'b1, 6'd30, 10'h50, 24'hABC, 1'b1, 8'hFF, 8'h00, 1'b1);
    drive(1'b1, 6'd31, 10'h51, 24'hABC, 1'b1, 8'hFF, 8'h00, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (!(bus.d3_vld_o === 1'b0 && bus.mhit_cnt_o === 8'd0 && act_vec() === '0)) begin
      errors++; $display("FAIL reset_mid_stall: got vld=%b cnt=%0d out=%h want 0 0 0", bus.d3_vld_o, bus.mhit_cnt_o, act_vec());
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 6'd32, 10'h50, 24'hABC, 1'b1, 8'hFF, 8'h00, 1'b1);
    checks++;
    if (!(bus.d3_way_o === 8'h01 && bus.d3_evict_o === 1'b1)) begin
      errors++; $display("FAIL post_reset_rr: got way=%h evict=%b want 01 1", bus.d3_way_o, bus.d3_evict_o);
    end
    idle();
  endtask

  task automatic test_random();
    logic [WAYS-1:0] lock;
    logic rdy;
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < WAYS; k++) tg[k] = TAG_W'($urandom_range(0, 3));
      lock = ($urandom_range(0, 9) == 0) ? 8'hFF : WAYS'($urandom & $urandom & $urandom);
      rdy  = ($urandom_range(0, 3) != 0);
      drive(($urandom_range(0, 3) != 0), ID_W'($urandom), SET_W'($urandom_range(0, 2)),
            TAG_W'($urandom_range(0, 4)), 1'($urandom), WAYS'($urandom), lock, rdy);
      checks++;
      if (act_vec() !== exp_vec() || bus.d2_rdy_o !== (!m_vld || rdy)) begin
        errors++; $display("FAIL random_%0d: got out=%h rdy=%b want out=%h rdy=%b", i, act_vec(), bus.d2_rdy_o,
                           exp_vec(), (!m_vld || rdy));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_invalid_first();
    test_round_robin();
    test_replay();
    test_stall_mhit();
    test_mhit_saturate();
    test_reset_mid_stall();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
